// File: rtl/maxnet_controller.sv
// maxnet_controller: sequencing FSM for the winner-take-all (MAXNET) datapath.
// Ports:
//   clk, rst (async, active-low)
//   start/ready          request handshake, start sampled only in IDLE
//   complete             datapath "single winner left" flag, looked at in CHECK
//   sel, en0..en3        datapath mux select and register load strobes
//   busy                 high while a run is in flight (not IDLE, not DONE)
//   result_valid/ack     completion handshake, valid held until acknowledged
//   timeout              qualifies result_valid: no convergence within MAX_ITER
//   iter_count           AReg updates performed in the current or last run
module maxnet_controller #(
    parameter int MAX_ITER = 31,
    parameter int CNT_W    = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             complete,
    input  logic             result_ack,
    output logic             ready,
    output logic             busy,
    output logic             sel,
    output logic             en0,
    output logic             en1,
    output logic             en2,
    output logic             en3,
    output logic             result_valid,
    output logic             timeout,
    output logic [CNT_W-1:0] iter_count
);
    typedef enum logic [2:0] {IDLE, LOAD, FIRST, ITER, ACC, CHECK, SELECT, DONE} state_t;

    localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_ITER);

    state_t state, nxt;

    // iter_count already includes the update made on the ACC edge when CHECK looks at it
    always_comb begin
        nxt = state;
        case (state)
            IDLE:        nxt = start ? LOAD : IDLE;
            LOAD:        nxt = FIRST;
            FIRST, ITER: nxt = ACC;
            ACC:         nxt = CHECK;
            CHECK:       nxt = complete ? SELECT : (iter_count == MAX_CNT) ? DONE : ITER;
            SELECT:      nxt = DONE;
            DONE:        nxt = result_ack ? IDLE : DONE;
            default:     nxt = IDLE;
        endcase
    end

    // Outputs are registered from the next state so they line up with the state register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state        <= IDLE;
            ready        <= 1'b1;
            busy         <= 1'b0;
            sel          <= 1'b0;
            en0          <= 1'b0;
            en1          <= 1'b0;
            en2          <= 1'b0;
            en3          <= 1'b0;
            result_valid <= 1'b0;
            timeout      <= 1'b0;
            iter_count   <= '0;
        end else begin
            state        <= nxt;
            ready        <= nxt == IDLE;
            busy         <= nxt != IDLE && nxt != DONE;
            sel          <= nxt == LOAD || nxt == FIRST;
            en0          <= nxt == LOAD;
            en1          <= nxt == FIRST || nxt == ITER;
            en2          <= nxt == ACC;
            en3          <= nxt == SELECT;
            result_valid <= nxt == DONE;
            if (state == IDLE && start) begin
                iter_count <= '0;
                timeout    <= 1'b0;
            end
            if (state == ACC && iter_count != '1)
                iter_count <= iter_count + 1'b1;
            if (state == CHECK && !complete && iter_count == MAX_CNT)
                timeout <= 1'b1;
        end
    end
endmodule

// File: tb/tb_maxnet_controller.sv
// tb_maxnet_controller: directed bench for maxnet_controller with a run-phase reference model.
module tb_maxnet_controller;
    localparam int CNT_W    = 5;
    localparam int MAX_ITER = 4;

    logic clk = 0, rst = 0, start = 0, complete = 0, result_ack = 0;
    logic ready, busy, sel, en0, en1, en2, en3, result_valid, timeout;
    logic [CNT_W-1:0] iter_count;

    maxnet_controller #(.MAX_ITER(MAX_ITER), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst), .start(start), .complete(complete), .result_ack(result_ack),
        .ready(ready), .busy(busy), .sel(sel), .en0(en0), .en1(en1), .en2(en2), .en3(en3),
        .result_valid(result_valid), .timeout(timeout), .iter_count(iter_count)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0, errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Model: a run is a count of cycles since start. p=1 load, p=2 first product,
    // then repeating groups of three cycles: accumulate, check, next product.
    int m_mode = 0;  // 0 idle, 1 running, 2 select, 3 done
    int m_p = 0, m_iter = 0;
    bit m_to = 0;

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            m_mode <= 0; m_p <= 0; m_iter <= 0; m_to <= 0;
        end else if (m_mode == 0) begin
            if (start) begin m_mode <= 1; m_p <= 1; m_iter <= 0; m_to <= 0; end
        end else if (m_mode == 1) begin
            if (m_p >= 3 && (m_p - 3) % 3 == 1) begin
                if (complete) m_mode <= 2;
                else if (m_iter == MAX_ITER) begin m_mode <= 3; m_to <= 1; end
                else m_p <= m_p + 1;
            end else begin
                if (m_p >= 3 && (m_p - 3) % 3 == 0 && m_iter < 2**CNT_W - 1) m_iter <= m_iter + 1;
                m_p <= m_p + 1;
            end
        end else if (m_mode == 2) begin
            m_mode <= 3;
        end else if (result_ack) begin
            m_mode <= 0;
        end
    end

    always @(negedge clk) begin
        int k;
        logic [7:0] e;
        k = (m_p >= 3) ? (m_p - 3) % 3 : -1;
        e = {m_mode == 0, m_mode == 1 || m_mode == 2, m_mode == 1 && m_p <= 2,
             m_mode == 1 && m_p == 1, m_mode == 1 && (m_p == 2 || k == 2),
             m_mode == 1 && k == 0, m_mode == 2, m_mode == 3};
        check("outs{rdy,busy,sel,en0..3,rv}", {ready, busy, sel, en0, en1, en2, en3, result_valid}, e);
        check("iter_count", iter_count, m_iter);
        check("enable_onehot", $countones({en0, en1, en2, en3}) <= 1, 1);
        if (m_mode == 3) check("timeout", timeout, m_to);
    end

    // Event log for the hand-computed timeline checks
    int en0_c, en1_c, en3_c, rv_n;
    int en2_q[$], sel_q[$];
    always @(negedge clk) begin
        if (en0 && en0_c < 0) en0_c = cyc;
        if (en1 && en1_c < 0) en1_c = cyc;
        if (en3 && en3_c < 0) en3_c = cyc;
        if (en2) en2_q.push_back(cyc);
        if (sel) sel_q.push_back(cyc);
        if (result_valid) rv_n++;
    end

    task automatic tick(input int n = 1);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    task automatic clr_log();
        en0_c = -1; en1_c = -1; en3_c = -1; rv_n = 0;
        en2_q.delete(); sel_q.delete();
    endtask

    // conv: index of the check at which complete is presented (0 = never)
    task automatic run(input int conv, input bit noise, output int t0, output int t_rv);
        bit seen = 0;
        clr_log();
        t0 = cyc;
        start = 1;
        tick();
        start = 0;
        for (int i = 0; i < 200 && !seen; i++) begin
            if (conv > 0 && cyc >= t0 + 4 + 3 * (conv - 1)) complete = 1;
            start = noise && cyc == t0 + 5;
            result_ack = noise && cyc == t0 + 7;
            if (result_valid) seen = 1;
            else tick();
        end
        start = 0; result_ack = 0; complete = 0;
        t_rv = cyc;
        if (!seen) check("result_valid_arrives", 0, 1);
    endtask

    task automatic ack(input int hold, input bit with_start);
        result_ack = 1;
        start = with_start;
        tick();
        start = 0;
        tick(hold - 1);
        result_ack = 0;
        tick();
    endtask

    int t0, trv;

    initial begin
        tick(3);
        check("reset_ready", ready, 1);
        check("reset_iter", iter_count, 0);
        rst = 1;
        tick(2);

        // Convergence at the first check
        run(1, 0, t0, trv);
        check("A_en0_cycle", en0_c - t0, 1);
        check("A_en1_cycle", en1_c - t0, 2);
        check("A_en2_count", en2_q.size(), 1);
        if (en2_q.size() > 0) check("A_en2_cycle", en2_q[0] - t0, 3);
        check("A_en3_cycle", en3_c - t0, 5);
        check("A_rv_cycle", trv - t0, 6);
        check("A_iter", iter_count, 1);
        check("A_timeout", timeout, 0);
        ack(1, 0);

        // Convergence at the third check, with start/ack noise while busy
        run(3, 1, t0, trv);
        check("B_en2_count", en2_q.size(), 3);
        if (en2_q.size() == 3) begin
            check("B_en2_c0", en2_q[0] - t0, 3);
            check("B_en2_c1", en2_q[1] - t0, 6);
            check("B_en2_c2", en2_q[2] - t0, 9);
        end
        check("B_sel_count", sel_q.size(), 2);
        if (sel_q.size() == 2) begin
            check("B_sel_c0", sel_q[0] - t0, 1);
            check("B_sel_c1", sel_q[1] - t0, 2);
        end
        check("B_en3_cycle", en3_c - t0, 11);
        check("B_iter", iter_count, 3);
        start = 1;
        tick();
        start = 0;
        check("B_start_in_done_ignored", result_valid, 1);
        ack(3, 1);
        check("B_back_idle", ready, 1);
        check("B_held_iter", iter_count, 3);

        // Timeout at MAX_ITER, then ack withheld for ten cycles
        run(0, 0, t0, trv);
        check("C_en2_count", en2_q.size(), 4);
        check("C_en3_never", en3_c, -1);
        check("C_rv_cycle", trv - t0, 14);
        check("C_iter", iter_count, 4);
        check("C_timeout", timeout, 1);
        clr_log();
        tick(10);
        check("C_rv_held", rv_n, 10);
        check("C_no_en2", en2_q.size(), 0);
        check("C_no_en", {en0_c, en1_c, en3_c}, {-32'sd1, -32'sd1, -32'sd1} == {en0_c, en1_c, en3_c} ? {en0_c, en1_c, en3_c} : {-32'sd1, -32'sd1, -32'sd1});
        check("C_no_en0", en0_c, -1);
        check("C_no_en1", en1_c, -1);
        ack(1, 0);

        // Fresh run after a timeout restarts the counter
        run(1, 0, t0, trv);
        check("D_iter", iter_count, 1);
        check("D_timeout", timeout, 0);
        check("D_rv_cycle", trv - t0, 6);
        ack(1, 0);

        // Reset pulled during ACC
        clr_log();
        t0 = cyc;
        start = 1;
        tick();
        start = 0;
        tick(2);
        rst = 0;
        tick();
        check("E_ready", ready, 1);
        check("E_en", {en0, en1, en2, en3}, 0);
        check("E_iter", iter_count, 0);
        check("E_rv", result_valid, 0);
        rst = 1;
        tick(2);
        check("E_idle", ready, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
